shared_unit_sequencer: RTL and testbench

//  Shares one fixed-latency multicycle functional unit (e.g. the PC/operand incrementer)

---
 rtl/shared_unit_sequencer.sv | 142 ++++++++++++++
 tb/tb_shared_unit_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_unit_sequencer.sv
// Round-robin sequencer sharing one fixed-latency multicycle unit between two requesters.
// Holds the winning operand for LAT cycles, captures the result and returns it tagged with the requester id.
module shared_unit_sequencer #(
    parameter int DATA_W = 32,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              unit_start,
    output logic [DATA_W-1:0] unit_opnd,
    input  logic [DATA_W-1:0] unit_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             id_r;
    logic             last_grant_r;
    logic             grant_valid_s;
    logic             grant_id_s;
    logic             handshake_s;
    logic             last_run_s;

    // Round-robin pick: a lone requester wins, a contest goes to the one not served last
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    assign handshake_s = (state_r == IDLE) && grant_valid_s;
    assign req0_ready  = handshake_s && !grant_id_s;
    assign req1_ready  = handshake_s && grant_id_s;
    assign last_run_s  = (state_r == RUN) && (cnt_r == {CNT_W{1'b0}});

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_run_s) begin
                    state_s = RESP;
                end else begin
                    state_s = RUN;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, latency counter and response capture; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_start   <= 1'b0;
            unit_opnd    <= {DATA_W{1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= {DATA_W{1'b0}};
            busy         <= 1'b0;
        end else begin
            unit_start <= handshake_s;
            busy       <= (state_s != IDLE);
            if (handshake_s) begin
                unit_opnd    <= grant_id_s ? req1_data : req0_data;
                id_r         <= grant_id_s;
                last_grant_r <= grant_id_s;
                cnt_r        <= CNT_W'(LAT - 1);
            end else if ((state_r == RUN) && !last_run_s) begin
                cnt_r <= cnt_r - 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (last_run_s) begin
                rsp_data  <= unit_result;
                rsp_id    <= id_r;
                rsp_valid <= 1'b1;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end else begin
                rsp_valid <= rsp_valid;
            end
        end
    end

endmodule

// File: tb/tb_shared_unit_sequencer.sv
// Bench for shared_unit_sequencer: three instances (LAT = 1, 3, 5) share one stimulus stream and are
// checked every cycle against a timestamp-based transaction model, plus hand-computed literal checks.
module tb_shared_unit_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = 32'd0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = 32'd0;
    logic        rsp_ready = 1'b0;

    logic        rdy0   [3];
    logic        rdy1   [3];
    logic        ustart [3];
    logic [31:0] uopnd  [3];
    logic [31:0] ures   [3];
    logic        rv     [3];
    logic        rid    [3];
    logic [31:0] rd     [3];
    logic        bsy    [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ures[g] = uopnd[g] + 32'd1;
        shared_unit_sequencer #(.DATA_W(32), .LAT(2 * g + 1)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_data  (req0_data),
            .req0_ready (rdy0[g]),
            .req1_valid (req1_valid),
            .req1_data  (req1_data),
            .req1_ready (rdy1[g]),
            .unit_start (ustart[g]),
            .unit_opnd  (uopnd[g]),
            .unit_result(ures[g]),
            .rsp_valid  (rv[g]),
            .rsp_id     (rid[g]),
            .rsp_data   (rd[g]),
            .rsp_ready  (rsp_ready),
            .busy       (bsy[g])
        );
    end

    // Transaction model: an operation is in flight from its handshake cycle until its response is taken.
    int unsigned cyc = 0;
    bit          armed = 1'b0;
    bit          m_busy [3] = '{1'b0, 1'b0, 1'b0};
    bit          m_last [3] = '{1'b1, 1'b1, 1'b1};
    bit          m_id   [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_opnd [3] = '{32'd0, 32'd0, 32'd0};
    int unsigned m_hs   [3] = '{0, 0, 0};

    function automatic int winner(bit last, logic v0, logic v1);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic bit resp_due(int k);
        return m_busy[k] && (cyc >= m_hs[k] + 32'(2 * k + 1) + 32'd1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w;
            w = winner(m_last[k], req0_valid, req1_valid);
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_last[k] <= 1'b1;
                m_opnd[k] <= 32'd0;
            end else if (!m_busy[k]) begin
                if (w >= 0) begin
                    m_busy[k] <= 1'b1;
                    m_hs[k]   <= cyc;
                    m_id[k]   <= (w == 1);
                    m_last[k] <= (w == 1);
                    m_opnd[k] <= (w == 1) ? req1_data : req0_data;
                end
            end else if (resp_due(k) && rsp_ready) begin
                m_busy[k] <= 1'b0;
            end
        end
        if (rst) armed <= 1'b1;
        cyc <= cyc + 1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                int w;
                bit due;
                w   = winner(m_last[k], req0_valid, req1_valid);
                due = resp_due(k);
                chk($sformatf("lat%0d req0_ready", 2 * k + 1), 32'(rdy0[k]), 32'(!m_busy[k] && w == 0));
                chk($sformatf("lat%0d req1_ready", 2 * k + 1), 32'(rdy1[k]), 32'(!m_busy[k] && w == 1));
                chk($sformatf("lat%0d unit_start", 2 * k + 1), 32'(ustart[k]), 32'(m_busy[k] && cyc == m_hs[k] + 1));
                chk($sformatf("lat%0d unit_opnd", 2 * k + 1), uopnd[k], m_opnd[k]);
                chk($sformatf("lat%0d busy", 2 * k + 1), 32'(bsy[k]), 32'(m_busy[k]));
                chk($sformatf("lat%0d rsp_valid", 2 * k + 1), 32'(rv[k]), 32'(due));
                if (due) begin
                    chk($sformatf("lat%0d rsp_id", 2 * k + 1), 32'(rid[k]), 32'(m_id[k]));
                    chk($sformatf("lat%0d rsp_data", 2 * k + 1), rd[k], m_opnd[k] + 32'd1);
                end
            end
        end
    end

    logic [32:0] rq[$];
    always @(negedge clk) begin
        if (rv[1] === 1'b1 && rsp_ready) rq.push_back({rid[1], rd[1]});
    end

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Scenario 1 / 6: reset values, then a lone req0 on all three latencies
        step(2);
        chk("reset rsp_valid", 32'(rv[1]), 32'd0);
        chk("reset rsp_data", rd[1], 32'd0);
        chk("reset unit_opnd", uopnd[1], 32'd0);
        chk("reset busy", 32'(bsy[1]), 32'd0);
        chk("reset unit_start", 32'(ustart[1]), 32'd0);
        rst = 1'b0; req0_valid = 1'b1; req0_data = 32'h10; #1;
        chk("s1 req0_ready at T", 32'(rdy0[1]), 32'd1);
        step(); req0_valid = 1'b0;
        chk("s1 unit_start at T+1", 32'(ustart[1]), 32'd1);
        step();
        chk("s6 lat1 rsp_valid T+2", 32'(rv[0]), 32'd1);
        chk("s6 lat1 rsp_data", rd[0], 32'h11);
        step();
        chk("s1 rsp_valid low T+3", 32'(rv[1]), 32'd0);
        step();
        chk("s1 rsp_valid T+4", 32'(rv[1]), 32'd1);
        chk("s1 rsp_data", rd[1], 32'h11);
        chk("s1 rsp_id", 32'(rid[1]), 32'd0);
        step();
        chk("s6 lat5 rsp_valid low T+5", 32'(rv[2]), 32'd0);
        step();
        chk("s6 lat5 rsp_valid T+6", 32'(rv[2]), 32'd1);
        chk("s6 lat5 rsp_data", rd[2], 32'h11);
        // Scenario 3: response held while rsp_ready stays low
        req0_valid = 1'b1; req0_data = 32'h40;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("s3 hold rsp_valid", 32'(rv[1]), 32'd1);
            chk("s3 hold rsp_data", rd[1], 32'h11);
            chk("s3 hold req0_ready", 32'(rdy0[1]), 32'd0);
            chk("s3 hold busy", 32'(bsy[1]), 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        chk("s3 idle after accept", 32'(bsy[1]), 32'd0);
        chk("s3 req0_ready after accept", 32'(rdy0[1]), 32'd1);
        step(); req0_valid = 1'b0;
        step(8);

        // Scenario 2: continuous contention from reset
        rst = 1'b1; req0_valid = 1'b1; req0_data = 32'h20; req1_valid = 1'b1; req1_data = 32'h30;
        step(); rst = 1'b0; rq.delete();
        step(22);
        chk("s2 response count", 32'(rq.size() >= 3), 32'd1);
        if (rq.size() >= 3) begin
            chk("s2 resp0", 32'(rq[0][32]) ^ rq[0][31:0], 32'h21);
            chk("s2 resp1 id", 32'(rq[1][32]), 32'd1);
            chk("s2 resp1 data", rq[1][31:0], 32'h31);
            chk("s2 resp2 id", 32'(rq[2][32]), 32'd0);
            chk("s2 resp2 data", rq[2][31:0], 32'h21);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(8);

        // Scenario 4: reset in the second RUN cycle aborts the operation
        req0_valid = 1'b1; req0_data = 32'h50;
        step(); req0_valid = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        chk("s4 busy after abort", 32'(bsy[1]), 32'd0);
        chk("s4 rsp_valid after abort", 32'(rv[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s4 no stale response", 32'(rv[1]), 32'd0);
        end
        req1_valid = 1'b1; req1_data = 32'h60; #1;
        chk("s4 req1_ready", 32'(rdy1[1]), 32'd1);
        step(); req1_valid = 1'b0;
        step(3);
        chk("s4 rsp_valid", 32'(rv[1]), 32'd1);
        chk("s4 rsp_id", 32'(rid[1]), 32'd1);
        chk("s4 rsp_data", rd[1], 32'h61);
        step(8);

        // Scenario 5: operand wrap
        req0_valid = 1'b1; req0_data = 32'hFFFF_FFFF;
        step(); req0_valid = 1'b0;
        step(3);
        chk("s5 rsp_valid", 32'(rv[1]), 32'd1);
        chk("s5 rsp_data wrap", rd[1], 32'h0000_0000);
        chk("s5 rsp_id", 32'(rid[1]), 32'd0);
        step(8);

        // Randomized traffic with occasional resets and back-pressure
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            req1_data  = $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
